ad9781_spi_master: RTL and testbench
====================================

// Module: ad9781_spi_master
// PURPOSE
//  Register-access engine for the AD9781 DAC serial port. Sits directly upstream of the DAC pin driver and feeds its
//  csb_in / sclk_in / sdio_inout / sdo_out passthrough pins. Takes one single-byte read or write request from local
//  control logic and runs one 16-bit SPI frame: an instruction byte followed by a data byte. Reports done and readback.
// PARAMETERS
//  CLK_DIV    4  clk cycles per SCLK half-period; legal range 2..255 (elaboration error otherwise)
//  CSB_SETUP  2  clk cycles CSB low before first SCLK rise; minimum 1
//  CSB_HOLD   2  clk cycles after last SCLK fall before CSB rises; minimum 1
//  SDO_4WIRE  0  0 = read data sampled on sdio_i (3-wire); 1 = read data sampled on sdo_i
// PORTS
//  clk      in   1  system clock; all logic on rising edge
//  rst_n    in   1  asynchronous, active-low reset
//  start    in   1  request strobe; accepted only when busy=0
//  rnw      in   1  1=read, 0=write; sampled with start
//  addr     in   5  register address; sampled with start
//  wdata    in   8  write data; sampled with start
//  busy     out  1  high from the cycle after accept until the gap completes
//  done     out  1  one-cycle pulse in the cycle CSB returns high
//  rdata    out  8  last read result; valid from done
//  csb      out  1  chip select to DAC, active low
//  sclk     out  1  serial clock to DAC, idle low
//  sdio_o   out  1  serial data out
//  sdio_oe  out  1  sdio output enable; top level builds the tristate
//  sdio_i   in   1  sdio pad input
//  sdo_i    in   1  DAC SDO input, used only when SDO_4WIRE=1
// BEHAVIOUR
//  Reset: csb=1, sclk=0, sdio_o=0, sdio_oe=0, busy=0, done=0, rdata=8'h00, FSM=IDLE.
//  Frame: shift register sr[15:0] = {rnw, 2'b00 (N1:N0, single byte), addr[4:0], rnw ? 8'h00 : wdata}. MSB first.
//  FSM states: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
//  - IDLE: if start, load sr. Next cycle: busy=1, csb=0, sdio_oe=1, sdio_o=sr[15]. Enter SETUP.
//  - SETUP: hold for CSB_SETUP cycles with sclk=0, then enter SHIFT.
//  - SHIFT: 16 bits. Each bit is CLK_DIV cycles with sclk=0, then CLK_DIV cycles with sclk=1.
//    On the sclk 0->1 cycle, capture the input bit (sdio_i or sdo_i) into rx[0] and shift rx left.
//    On each sclk 1->0 edge, shift sr and drive the next bit on sdio_o.
//    Read only: sdio_oe drops together with the falling edge ending bit 7 (last instruction bit).
//    It stays 0 for the data phase. For writes, sdio_oe stays 1.
//  - HOLD: after the 16th fall, sclk=0 for CSB_HOLD cycles. Then csb=1 and sdio_oe=0.
//    done pulses for 1 cycle; on reads, rdata <= rx[7:0].
//  - GAP: csb stays high for CLK_DIV cycles with busy=1. Then IDLE and busy=0.
//  Latency start->done = 1 + CSB_SETUP + 32*CLK_DIV + CSB_HOLD cycles.
//  Latency start->busy low = that + CLK_DIV.
//  Writes never change rdata. rdata holds until the next read completes.
//  start while busy=1: ignored, no queueing, no error flag.
//  start in the same cycle busy falls (busy=0 that cycle): accepted.
//  Reset asserted mid-frame: all outputs return to reset values asynchronously and the frame is abandoned.
//  No done pulse is issued for the abandoned frame.
//  Bit counter is 4 bits wide (0..15) and terminates at 15 with no wrap. The divider counter is 8 bits.
// STRUCTURE
//  Include file ad9781_spi_defs.vh holds the FSM state encodings, instruction field positions (RNW=7, N=6:5, ADDR=4:0)
//  and the frame length constant 16. One natural sub-module is spi_tick_gen: a CLK_DIV divider that emits
//  rise/fall strike pulses and is enabled only in SHIFT. The FSM and shift registers stay in this module.
// TESTING
//  1. CLK_DIV=2, write addr=5'h02 wdata=8'hA5 -> sdio_o sampled at sclk rises = 16'h02A5; exactly 16 rises.
//     sdio_oe=1 throughout; done at cycle 1+2+64+2=69 after accept; rdata unchanged.
//  2. Read addr=5'h1F with the DAC model returning 8'h3C on sdio_i -> instruction 8'h9F on the wire.
//     sdio_oe=0 from the fall after bit 7 until csb high; rdata=8'h3C at done.
//  3. SDO_4WIRE=1, read with sdio_i tied 0 and sdo_i returning 8'hC3 -> rdata=8'hC3.
//  4. start pulsed every cycle during a frame -> only one frame runs. A second frame starts on the first cycle busy=0.
//  5. rst_n low at bit 9 of a write -> csb=1, sclk=0, sdio_oe=0 immediately and no done.
//     The next request runs a full correct frame.
//  6. Checkers across CLK_DIV in {2,4,7}: sclk low/high phases are exactly CLK_DIV cycles, csb low->first rise is
//     CSB_SETUP+CLK_DIV cycles, and the csb high gap is >=CLK_DIV cycles.

Source files
------------

// File: rtl/ad9781_spi_master_pkg.sv
// Shared types and constants for the AD9781 serial-port register-access engine.
// The instruction byte layout lives here so the frame builder and the FSM agree on it.
package ad9781_spi_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } state_t;

    localparam int FRAME_LEN      = 16;
    localparam int INSTR_RNW      = 7;
    localparam int INSTR_N_MSB    = 6;
    localparam int INSTR_N_LSB    = 5;
    localparam int INSTR_ADDR_MSB = 4;

    localparam logic [1:0] N_SINGLE_BYTE = 2'b00;

    // Reads clock out a zero data byte; the DAC owns the line during that phase.
    function automatic logic [FRAME_LEN-1:0] build_frame(input logic       rnw,
                                                         input logic [4:0] addr,
                                                         input logic [7:0] wdata);
        logic [7:0] instr;
        instr                          = '0;
        instr[INSTR_RNW]               = rnw;
        instr[INSTR_N_MSB:INSTR_N_LSB] = N_SINGLE_BYTE;
        instr[INSTR_ADDR_MSB:0]        = addr;
        return {instr, (rnw ? 8'h00 : wdata)};
    endfunction

endpackage

// File: rtl/ad9781_spi_master_tick_gen.sv
// SCLK divider: CLK_DIV clk cycles per half-period, strobing rise/fall on the cycle whose
// closing edge moves sclk. Held cleared while disabled so every frame starts with a full low phase.
module ad9781_spi_master_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic sclk,
    output logic rise,
    output logic fall
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [7:0] div_cnt;
    logic       phase;
    logic       term;

    assign term = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            phase   <= 1'b0;
        end else if (!en) begin
            div_cnt <= '0;
            phase   <= 1'b0;
        end else if (term) begin
            div_cnt <= '0;
            phase   <= ~phase;
        end else begin
            div_cnt <= div_cnt + 8'd1;
        end
    end

    assign sclk = phase;
    assign rise = en & term & ~phase;
    assign fall = en & term & phase;

endmodule

// File: rtl/ad9781_spi_master.sv
// AD9781 serial-port master: runs one 16-bit single-byte read or write frame per accepted request.
// Pin-level outputs are decoded from registered state so reset returns them to idle asynchronously.
module ad9781_spi_master
    import ad9781_spi_master_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int CSB_SETUP = 2,
    parameter int CSB_HOLD  = 2,
    parameter int SDO_4WIRE = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       rnw,
    input  logic [4:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       csb,
    output logic       sclk,
    output logic       sdio_o,
    output logic       sdio_oe,
    input  logic       sdio_i,
    input  logic       sdo_i
);

    if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_bad_clk_div
        $error("ad9781_spi_master: CLK_DIV must be within 2..255");
    end
    if (CSB_SETUP < 1 || CSB_SETUP > 256) begin : g_bad_setup
        $error("ad9781_spi_master: CSB_SETUP must be within 1..256");
    end
    if (CSB_HOLD < 1 || CSB_HOLD > 256) begin : g_bad_hold
        $error("ad9781_spi_master: CSB_HOLD must be within 1..256");
    end

    localparam logic [7:0] SETUP_LAST = 8'(CSB_SETUP - 1);
    localparam logic [7:0] HOLD_LAST  = 8'(CSB_HOLD - 1);
    localparam logic [7:0] GAP_LAST   = 8'(CLK_DIV - 1);
    localparam logic [3:0] LAST_BIT   = 4'(FRAME_LEN - 1);

    state_t     state;
    state_t     state_next;
    logic [7:0] wait_cnt;
    logic [3:0] bit_cnt;
    logic [FRAME_LEN-1:0] sr;
    logic [7:0] rx;
    logic       rnw_q;
    logic       tick_rise;
    logic       tick_fall;
    logic       rx_bit;

    ad9781_spi_master_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (state == ST_SHIFT),
        .sclk (sclk),
        .rise (tick_rise),
        .fall (tick_fall)
    );

    assign rx_bit = (SDO_4WIRE != 0) ? sdo_i : sdio_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start)                                  state_next = ST_SETUP;
            ST_SETUP: if (wait_cnt == SETUP_LAST)                 state_next = ST_SHIFT;
            ST_SHIFT: if (tick_fall && (bit_cnt == LAST_BIT))     state_next = ST_HOLD;
            ST_HOLD:  if (wait_cnt == HOLD_LAST)                  state_next = ST_GAP;
            ST_GAP:   if (wait_cnt == GAP_LAST)                   state_next = ST_IDLE;
            default:                                              state_next = ST_IDLE;
        endcase
    end

    // wait_cnt times SETUP/HOLD/GAP; the bit counter parks at 15 rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            bit_cnt  <= '0;
            sr       <= '0;
            rx       <= '0;
            rnw_q    <= 1'b0;
            rdata    <= 8'h00;
        end else begin
            if ((state_next != state) || (state == ST_IDLE) || (state == ST_SHIFT)) begin
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if ((state == ST_IDLE) && start) begin
                sr      <= build_frame(rnw, addr, wdata);
                rnw_q   <= rnw;
                bit_cnt <= '0;
            end
            if (tick_rise) begin
                rx <= {rx[6:0], rx_bit};
            end
            if (tick_fall) begin
                sr <= {sr[FRAME_LEN-2:0], 1'b0};
                if (bit_cnt != LAST_BIT) begin
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end
            if ((state == ST_HOLD) && (state_next == ST_GAP) && rnw_q) begin
                rdata <= rx;
            end
        end
    end

    // On reads the line is released once bit_cnt reaches the data byte (bit_cnt[3] set).
    assign busy    = (state != ST_IDLE);
    assign csb     = !((state == ST_SETUP) || (state == ST_SHIFT) || (state == ST_HOLD));
    assign done    = (state == ST_GAP) && (wait_cnt == 8'd0);
    assign sdio_o  = sr[FRAME_LEN-1];
    assign sdio_oe = !csb && !(rnw_q && bit_cnt[3]);

endmodule

// File: tb/tb_ad9781_spi_master.sv
// Directed bench for ad9781_spi_master: three instances (CLK_DIV 2, 4 with 4-wire readback, 7)
// share stimulus; sel picks which one is driven and observed.
module tb_ad9781_spi_master;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       rnw   = 1'b0;
    logic [4:0] addr  = '0;
    logic [7:0] wdata = '0;
    logic       sdio_i = 1'b0;
    logic       sdo_i  = 1'b0;
    logic [1:0] sel    = 2'd0;

    logic [2:0] busy_w, done_w, csb_w, sclk_w, sdio_o_w, sdio_oe_w;
    logic [7:0] rdata_w [3];

    logic       busy_m, done_m, csb_m, sclk_m, sdio_o_m, sdio_oe_m, four_wire;
    logic [7:0] rdata_m;

    int n_cmp = 0;
    int n_mis = 0;

    logic [15:0] mosi;
    logic [7:0]  rdata_done;
    int rise_cnt, fall_cnt, oe_err, phase_err, done_cyc, done_cnt;
    int busy_low_cyc, csb_to_rise, hold_len, gap_cnt;
    logic [47:0] counts_v;
    logic [63:0] timing_v;

    always #5 clk = ~clk;

    ad9781_spi_master #(.CLK_DIV(2), .CSB_SETUP(2), .CSB_HOLD(2), .SDO_4WIRE(0)) dut_div2 (
        .clk(clk), .rst_n(rst_n), .start(start && (sel == 2'd0)), .rnw(rnw), .addr(addr),
        .wdata(wdata), .busy(busy_w[0]), .done(done_w[0]), .rdata(rdata_w[0]), .csb(csb_w[0]),
        .sclk(sclk_w[0]), .sdio_o(sdio_o_w[0]), .sdio_oe(sdio_oe_w[0]), .sdio_i(sdio_i), .sdo_i(sdo_i));

    ad9781_spi_master #(.CLK_DIV(4), .CSB_SETUP(2), .CSB_HOLD(2), .SDO_4WIRE(1)) dut_div4 (
        .clk(clk), .rst_n(rst_n), .start(start && (sel == 2'd1)), .rnw(rnw), .addr(addr),
        .wdata(wdata), .busy(busy_w[1]), .done(done_w[1]), .rdata(rdata_w[1]), .csb(csb_w[1]),
        .sclk(sclk_w[1]), .sdio_o(sdio_o_w[1]), .sdio_oe(sdio_oe_w[1]), .sdio_i(sdio_i), .sdo_i(sdo_i));

    ad9781_spi_master #(.CLK_DIV(7), .CSB_SETUP(2), .CSB_HOLD(2), .SDO_4WIRE(0)) dut_div7 (
        .clk(clk), .rst_n(rst_n), .start(start && (sel == 2'd2)), .rnw(rnw), .addr(addr),
        .wdata(wdata), .busy(busy_w[2]), .done(done_w[2]), .rdata(rdata_w[2]), .csb(csb_w[2]),
        .sclk(sclk_w[2]), .sdio_o(sdio_o_w[2]), .sdio_oe(sdio_oe_w[2]), .sdio_i(sdio_i), .sdo_i(sdo_i));

    assign busy_m    = busy_w[sel];
    assign done_m    = done_w[sel];
    assign csb_m     = csb_w[sel];
    assign sclk_m    = sclk_w[sel];
    assign sdio_o_m  = sdio_o_w[sel];
    assign sdio_oe_m = sdio_oe_w[sel];
    assign rdata_m   = rdata_w[sel];
    assign four_wire = (sel == 2'd1);

    function automatic int div_of(input logic [1:0] s);
        case (s)
            2'd1:    return 4;
            2'd2:    return 7;
            default: return 2;
        endcase
    endfunction

    // Watches one frame from the first cycle after accept until busy drops, playing the DAC on reads.
    task automatic monitor_frame(input logic r, input logic [7:0] dac, input int div, input bit hammer);
        logic prev_sclk, prev_csb, exp_oe, b;
        int   lo_run, hi_run;
        bit   finished;
        prev_sclk = 1'b0; prev_csb = 1'b0; lo_run = 0; hi_run = 0; finished = 1'b0;
        mosi = '0; rise_cnt = 0; fall_cnt = 0; oe_err = 0; phase_err = 0; done_cyc = -1;
        done_cnt = 0; busy_low_cyc = -1; csb_to_rise = -1; hold_len = -1; gap_cnt = 0;
        rdata_done = 8'h00; sdio_i = 1'b0; sdo_i = 1'b0;
        for (int cyc = 1; cyc <= 3000 && !finished; cyc++) begin
            if (sclk_m && !prev_sclk) begin
                rise_cnt++;
                mosi = {mosi[14:0], sdio_o_m};
                if (rise_cnt == 1) csb_to_rise = lo_run;
                else if (lo_run != div) phase_err++;
                hi_run = 1;
            end else if (sclk_m) begin
                hi_run++;
            end else if (prev_sclk) begin
                fall_cnt++;
                if (hi_run != div) phase_err++;
                lo_run = 1;
                if (rise_cnt >= 8 && rise_cnt < 16) begin
                    b = dac[15 - rise_cnt];
                    if (four_wire) sdo_i = b;
                    else begin sdio_i = b; sdo_i = ~b; end
                end
            end else if (!csb_m) begin
                lo_run++;
            end
            if (csb_m && !prev_csb) hold_len = lo_run;
            exp_oe = !csb_m && !(r && fall_cnt >= 8);
            if (sdio_oe_m !== exp_oe) oe_err++;
            if (done_m === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) begin done_cyc = cyc; rdata_done = rdata_m; end
            end
            if (done_cyc >= 0 && csb_m) gap_cnt++;
            prev_sclk = sclk_m;
            prev_csb  = csb_m;
            if (busy_m === 1'b0) begin
                busy_low_cyc = cyc;
                finished = 1'b1;
            end else begin
                if (hammer) begin
                    start = 1'b1; rnw = 1'($urandom); addr = 5'($urandom); wdata = 8'($urandom);
                end
                @(negedge clk);
            end
        end
        sdio_i = 1'b0; sdo_i = 1'b0;
        counts_v = {8'(rise_cnt), 8'(fall_cnt), 8'(oe_err), 8'(phase_err), 8'(done_cnt), 8'(gap_cnt)};
        timing_v = {16'(csb_to_rise), 16'(hold_len), 16'(done_cyc), 16'(busy_low_cyc)};
        n_cmp++;
        if (!finished) begin
            n_mis++;
            $display("[TB] FAIL frame_timeout: busy=%b still high, expected low within 3000 cycles", busy_m);
        end
    endtask

    task automatic run_frame(input logic r, input logic [4:0] a, input logic [7:0] w, input logic [7:0] dac);
        @(negedge clk);
        rnw = r; addr = a; wdata = w; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        monitor_frame(r, dac, div_of(sel), 1'b0);
    endtask

    task automatic test_reset;
        sel = 2'd0; rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (csb_w !== 3'b111) begin n_mis++; $display("[TB] FAIL reset_csb: got %b expected 111", csb_w); end
        n_cmp++; if (sclk_w !== 3'b000) begin n_mis++; $display("[TB] FAIL reset_sclk: got %b expected 000", sclk_w); end
        n_cmp++; if (sdio_o_w !== 3'b000) begin n_mis++; $display("[TB] FAIL reset_sdio_o: got %b expected 000", sdio_o_w); end
        n_cmp++; if (sdio_oe_w !== 3'b000) begin n_mis++; $display("[TB] FAIL reset_sdio_oe: got %b expected 000", sdio_oe_w); end
        n_cmp++; if (busy_w !== 3'b000) begin n_mis++; $display("[TB] FAIL reset_busy: got %b expected 000", busy_w); end
        n_cmp++; if (done_w !== 3'b000) begin n_mis++; $display("[TB] FAIL reset_done: got %b expected 000", done_w); end
        n_cmp++; if ({rdata_w[0], rdata_w[1], rdata_w[2]} !== 24'h0) begin
            n_mis++; $display("[TB] FAIL reset_rdata: got %h%h%h expected 000000", rdata_w[0], rdata_w[1], rdata_w[2]);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write;
        sel = 2'd0;
        run_frame(1'b0, 5'h02, 8'hA5, 8'h00);
        n_cmp++; if (mosi !== 16'h02A5) begin n_mis++; $display("[TB] FAIL write_mosi: got %h expected 02a5", mosi); end
        n_cmp++; if (counts_v !== {8'd16, 8'd16, 8'd0, 8'd0, 8'd1, 8'd3}) begin
            n_mis++; $display("[TB] FAIL write_counts: got %h expected 101000000103", counts_v); end
        n_cmp++; if (timing_v !== {16'd4, 16'd2, 16'd69, 16'd71}) begin
            n_mis++; $display("[TB] FAIL write_timing: got %h expected %h", timing_v, {16'd4, 16'd2, 16'd69, 16'd71}); end
        n_cmp++; if (rdata_done !== 8'h00) begin n_mis++; $display("[TB] FAIL write_rdata: got %h expected 00", rdata_done); end
    endtask

    task automatic test_read;
        sel = 2'd0;
        run_frame(1'b1, 5'h1F, 8'hFF, 8'h3C);
        n_cmp++; if (mosi !== 16'h9F00) begin n_mis++; $display("[TB] FAIL read_mosi: got %h expected 9f00", mosi); end
        n_cmp++; if (counts_v !== {8'd16, 8'd16, 8'd0, 8'd0, 8'd1, 8'd3}) begin
            n_mis++; $display("[TB] FAIL read_counts: got %h expected 101000000103", counts_v); end
        n_cmp++; if (timing_v !== {16'd4, 16'd2, 16'd69, 16'd71}) begin
            n_mis++; $display("[TB] FAIL read_timing: got %h expected %h", timing_v, {16'd4, 16'd2, 16'd69, 16'd71}); end
        n_cmp++; if (rdata_done !== 8'h3C) begin n_mis++; $display("[TB] FAIL read_rdata: got %h expected 3c", rdata_done); end
    endtask

    task automatic test_back_to_back;
        sel = 2'd0;
        @(negedge clk);
        rnw = 1'b0; addr = 5'h02; wdata = 8'hA5; start = 1'b1;
        @(negedge clk);
        monitor_frame(1'b0, 8'h00, 2, 1'b1);
        rnw = 1'b0; addr = 5'h05; wdata = 8'h3E;
        n_cmp++; if (mosi !== 16'h02A5) begin n_mis++; $display("[TB] FAIL b2b_first_mosi: got %h expected 02a5", mosi); end
        n_cmp++; if (counts_v !== {8'd16, 8'd16, 8'd0, 8'd0, 8'd1, 8'd3}) begin
            n_mis++; $display("[TB] FAIL b2b_first_counts: got %h expected 101000000103", counts_v); end
        n_cmp++; if (timing_v !== {16'd4, 16'd2, 16'd69, 16'd71}) begin
            n_mis++; $display("[TB] FAIL b2b_first_timing: got %h expected %h", timing_v, {16'd4, 16'd2, 16'd69, 16'd71}); end
        @(negedge clk);
        start = 1'b0;
        n_cmp++; if ({csb_m, busy_m} !== 2'b01) begin
            n_mis++; $display("[TB] FAIL b2b_restart: got csb,busy=%b%b expected 01", csb_m, busy_m); end
        monitor_frame(1'b0, 8'h00, 2, 1'b0);
        n_cmp++; if (mosi !== 16'h053E) begin n_mis++; $display("[TB] FAIL b2b_second_mosi: got %h expected 053e", mosi); end
        n_cmp++; if (done_cyc !== 69) begin n_mis++; $display("[TB] FAIL b2b_second_done: got %0d expected 69", done_cyc); end
        n_cmp++; if (rdata_m !== 8'h3C) begin n_mis++; $display("[TB] FAIL b2b_rdata_kept: got %h expected 3c", rdata_m); end
    endtask

    task automatic test_reset_mid_frame;
        int done_seen;
        sel = 2'd0; done_seen = 0;
        @(negedge clk);
        rnw = 1'b0; addr = 5'h02; wdata = 8'hA5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        n_cmp++; if (sclk_m !== 1'b1) begin n_mis++; $display("[TB] FAIL midrst_bit9_high: got sclk=%b expected 1", sclk_m); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({csb_m, sclk_m, sdio_oe_m, busy_m, done_m} !== 5'b10000) begin
            n_mis++; $display("[TB] FAIL midrst_outputs: got %b expected 10000",
                              {csb_m, sclk_m, sdio_oe_m, busy_m, done_m}); end
        n_cmp++; if (rdata_m !== 8'h00) begin n_mis++; $display("[TB] FAIL midrst_rdata: got %h expected 00", rdata_m); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (done_m !== 1'b0) done_seen++;
            @(negedge clk);
        end
        n_cmp++; if (done_seen !== 0) begin n_mis++; $display("[TB] FAIL midrst_no_done: got %0d pulses expected 0", done_seen); end
        run_frame(1'b0, 5'h11, 8'h96, 8'h00);
        n_cmp++; if (mosi !== 16'h1196) begin n_mis++; $display("[TB] FAIL midrst_next_mosi: got %h expected 1196", mosi); end
        n_cmp++; if (timing_v !== {16'd4, 16'd2, 16'd69, 16'd71}) begin
            n_mis++; $display("[TB] FAIL midrst_next_timing: got %h expected %h", timing_v, {16'd4, 16'd2, 16'd69, 16'd71}); end
    endtask

    task automatic test_four_wire;
        sel = 2'd1;
        run_frame(1'b1, 5'h0C, 8'h00, 8'hC3);
        n_cmp++; if (mosi !== 16'h8C00) begin n_mis++; $display("[TB] FAIL fourwire_mosi: got %h expected 8c00", mosi); end
        n_cmp++; if (counts_v !== {8'd16, 8'd16, 8'd0, 8'd0, 8'd1, 8'd5}) begin
            n_mis++; $display("[TB] FAIL fourwire_counts: got %h expected 101000000105", counts_v); end
        n_cmp++; if (timing_v !== {16'd6, 16'd2, 16'd133, 16'd137}) begin
            n_mis++; $display("[TB] FAIL fourwire_timing: got %h expected %h", timing_v, {16'd6, 16'd2, 16'd133, 16'd137}); end
        n_cmp++; if (rdata_done !== 8'hC3) begin n_mis++; $display("[TB] FAIL fourwire_rdata: got %h expected c3", rdata_done); end
    endtask

    task automatic test_div7;
        sel = 2'd2;
        run_frame(1'b0, 5'h0A, 8'h5C, 8'h00);
        n_cmp++; if (mosi !== 16'h0A5C) begin n_mis++; $display("[TB] FAIL div7_mosi: got %h expected 0a5c", mosi); end
        n_cmp++; if (counts_v !== {8'd16, 8'd16, 8'd0, 8'd0, 8'd1, 8'd8}) begin
            n_mis++; $display("[TB] FAIL div7_counts: got %h expected 101000000108", counts_v); end
        n_cmp++; if (timing_v !== {16'd9, 16'd2, 16'd229, 16'd236}) begin
            n_mis++; $display("[TB] FAIL div7_timing: got %h expected %h", timing_v, {16'd9, 16'd2, 16'd229, 16'd236}); end
        n_cmp++; if (rdata_done !== 8'h00) begin n_mis++; $display("[TB] FAIL div7_rdata: got %h expected 00", rdata_done); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_reset_mid_frame();
        test_four_wire();
        test_div7();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
